p_inside_tri: RTL and testbench

//  Downstream neighbour of the hit-point stage. Pops one hit point P (origin + t*dir) with its triangle
//  (v0,v1,v2,normal) from show-ahead FIFOs, runs three sequential edge tests ((vb-va)x(P-va)).n >= 0
//  on one shared cross/dot datapath, and buffers a hit flag plus P for the shading stage.

---
 rtl/ray_fixed_pkg.sv | 25 ++
 rtl/p_inside_tri_cross3.sv | 31 +++
 rtl/p_inside_tri.sv | 136 +++++++++++++
 tb/tb_p_inside_tri.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ray_fixed_pkg.sv
// Fixed-point types and multiply helpers shared by the ray/triangle pipeline stages.
package ray_fixed_pkg;

  typedef logic signed [31:0] fixed_t;
  typedef fixed_t [2:0]       vec3_t;
  typedef logic signed [63:0] wide_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CROSS = 2'd1,
    DOT   = 2'd2
  } p_inside_state_t;

  // Full-precision product rescaled by q fractional bits, kept at 64 bits.
  function automatic wide_t fx_mul_wide(input fixed_t a, input fixed_t b, input int q);
    wide_t prod;
    prod = wide_t'(a) * wide_t'(b);
    return prod >>> q;
  endfunction

  function automatic fixed_t fx_mul(input fixed_t a, input fixed_t b, input int q);
    return fixed_t'(fx_mul_wide(a, b, q));
  endfunction

endpackage

// File: rtl/p_inside_tri_cross3.sv
// Registered fixed-point cross product c = e x w; each term is truncated to 32 bits before the wrap subtract.
module cross3
  import ray_fixed_pkg::*;
#(
  parameter int Q_BITS = 16
) (
  input  logic  clock,
  input  logic  i_en,
  input  vec3_t i_e,
  input  vec3_t i_w,
  output vec3_t o_c
);

  vec3_t w_c;
  vec3_t r_c_p1;

  always_comb begin
    w_c    = '0;
    w_c[0] = fx_mul(i_e[1], i_w[2], Q_BITS) - fx_mul(i_e[2], i_w[1], Q_BITS);
    w_c[1] = fx_mul(i_e[2], i_w[0], Q_BITS) - fx_mul(i_e[0], i_w[2], Q_BITS);
    w_c[2] = fx_mul(i_e[0], i_w[1], Q_BITS) - fx_mul(i_e[1], i_w[0], Q_BITS);
  end

  // Stage p1: cross product held steady through DOT, including any output stall.
  always_ff @(posedge clock) begin
    if (i_en) r_c_p1 <= w_c;
  end

  assign o_c = r_c_p1;

endmodule

// File: rtl/p_inside_tri.sv
// Point-in-triangle test: three sequential edge tests on one shared cross/dot datapath, one-slot output.
// Optional build macro P_INSIDE_EARLY_EXIT_EN writes a miss as soon as one edge fails.
module p_inside_tri
  import ray_fixed_pkg::*;
#(
  parameter int Q_BITS = 16
) (
  input  logic  clock,
  input  logic  reset,
  input  vec3_t p,
  input  vec3_t v0,
  input  vec3_t v1,
  input  vec3_t v2,
  input  vec3_t normal,
  input  logic  in_empty,
  output logic  in_rd_en,
  output logic  out_hit,
  output vec3_t out_p,
  output logic  out_empty,
  input  logic  out_rd_en
);

  p_inside_state_t r_state;
  logic [1:0]      r_idx;
  logic            r_pass;
  logic            r_out_hit;
  vec3_t           r_out_p;
  logic            r_out_empty;

  vec3_t r_p_p0, r_v0_p0, r_v1_p0, r_v2_p0, r_n_p0;

  vec3_t w_va, w_vb, w_e, w_w, w_c;
  wide_t w_s;
  logic  w_fail, w_pass_next, w_last, w_slot_free, w_wr;

  // Pops are blocked for the whole time reset is high, even though the FSM already sits in IDLE.
  assign in_rd_en = !reset && (r_state == IDLE) && !in_empty;

  // Stage p0: transaction captured on the pop.
  always_ff @(posedge clock) begin
    if (in_rd_en) begin
      r_p_p0  <= p;
      r_v0_p0 <= v0;
      r_v1_p0 <= v1;
      r_v2_p0 <= v2;
      r_n_p0  <= normal;
    end
  end

  always_comb begin
    w_va = r_v0_p0;
    w_vb = r_v1_p0;
    case (r_idx)
      2'd1: begin w_va = r_v1_p0; w_vb = r_v2_p0; end
      2'd2: begin w_va = r_v2_p0; w_vb = r_v0_p0; end
      default: begin w_va = r_v0_p0; w_vb = r_v1_p0; end
    endcase
    w_e = '0;
    w_w = '0;
    for (int k = 0; k < 3; k++) begin
      w_e[k] = w_vb[k] - w_va[k];
      w_w[k] = r_p_p0[k] - w_va[k];
    end
  end

  cross3 #(.Q_BITS(Q_BITS)) u_cross3 (
    .clock (clock),
    .i_en  (r_state == CROSS),
    .i_e   (w_e),
    .i_w   (w_w),
    .o_c   (w_c)
  );

  // Stage p2: dot with the normal at full 64-bit width, sign decides the edge.
  always_comb begin
    w_s = '0;
    for (int k = 0; k < 3; k++) w_s = w_s + fx_mul_wide(w_c[k], r_n_p0[k], Q_BITS);
  end

  assign w_fail      = (w_s < 0);
  assign w_pass_next = r_pass & ~w_fail;
`ifdef P_INSIDE_EARLY_EXIT_EN
  assign w_last      = (r_idx == 2'd2) || w_fail;
`else
  assign w_last      = (r_idx == 2'd2);
`endif
  assign w_slot_free = r_out_empty | out_rd_en;
  assign w_wr        = (r_state == DOT) && w_last && w_slot_free;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_idx       <= 2'd0;
      r_pass      <= 1'b0;
      r_out_hit   <= 1'b0;
      r_out_p     <= '0;
      r_out_empty <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_rd_en) begin
            r_idx   <= 2'd0;
            r_pass  <= 1'b1;
            r_state <= CROSS;
          end
        end
        CROSS: r_state <= DOT;
        DOT: begin
          if (!w_last) begin
            r_pass  <= w_pass_next;
            r_idx   <= r_idx + 2'd1;
            r_state <= CROSS;
          end else if (w_slot_free) begin
            r_idx   <= 2'd0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      // A write in the same cycle as a consumer pop replaces the old result; the slot stays full.
      if (w_wr) begin
        r_out_hit   <= w_pass_next;
        r_out_p     <= r_p_p0;
        r_out_empty <= 1'b0;
      end else if (out_rd_en) begin
        r_out_empty <= 1'b1;
      end
    end
  end

  assign out_hit   = r_out_hit;
  assign out_p     = r_out_p;
  assign out_empty = r_out_empty;

endmodule

// File: tb/tb_p_inside_tri.sv
// Bench for p_inside_tri: directed vector table, stall/reset sequences, random run against a scoreboard.
module tb_p_inside_tri;
  import ray_fixed_pkg::*;

`ifdef P_INSIDE_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  localparam int NRAND = 100;

  typedef struct {
    vec3_t p;
    vec3_t n;
    bit    hit;
    int    lat_def;
    int    lat_ee;
  } vec_t;

  typedef struct {
    bit    hit;
    vec3_t p;
  } res_t;

  logic  clock = 1'b0;
  logic  reset;
  vec3_t p, v0, v1, v2, normal, out_p;
  logic  in_empty, in_rd_en, out_hit, out_empty, out_rd_en;

  int    checks = 0;
  int    failures = 0;
  vec_t  tbl[8];
  res_t  q[$];
  res_t  r;
  vec3_t T0, T1, T2, NZ, PA, PB, rp, ra, rb, rc, rn;
  int    lat, exp_lat, seen, npush, ncons, cyc;
  bit    bad, need;

  always #5 clock = ~clock;

  p_inside_tri #(.Q_BITS(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .p         (p),
    .v0        (v0),
    .v1        (v1),
    .v2        (v2),
    .normal    (normal),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .out_hit   (out_hit),
    .out_p     (out_p),
    .out_empty (out_empty),
    .out_rd_en (out_rd_en)
  );

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec3_t v3(input int x, input int y, input int z);
    vec3_t t;
    t[0] = x; t[1] = y; t[2] = z;
    return t;
  endfunction

  function automatic int fx(input int a, input int b);
    longint m;
    m = longint'(a) * longint'(b);
    m = m >>> 16;
    return int'(m);
  endfunction

  function automatic vec3_t vsub(input vec3_t a, input vec3_t b);
    vec3_t t;
    for (int k = 0; k < 3; k++) t[k] = a[k] - b[k];
    return t;
  endfunction

  function automatic vec3_t vcross(input vec3_t a, input vec3_t b);
    vec3_t t;
    t[0] = fx(a[1], b[2]) - fx(a[2], b[1]);
    t[1] = fx(a[2], b[0]) - fx(a[0], b[2]);
    t[2] = fx(a[0], b[1]) - fx(a[1], b[0]);
    return t;
  endfunction

  function automatic bit model_hit(input vec3_t pp, input vec3_t a0, input vec3_t a1,
                                   input vec3_t a2, input vec3_t nn);
    vec3_t  vs[3];
    vec3_t  c;
    longint s;
    bit     pass;
    pass = 1'b1;
    vs[0] = a0; vs[1] = a1; vs[2] = a2;
    for (int k = 0; k < 3; k++) begin
      c = vcross(vsub(vs[(k + 1) % 3], vs[k]), vsub(pp, vs[k]));
      s = 0;
      for (int j = 0; j < 3; j++) s = s + ((longint'(c[j]) * longint'(nn[j])) >>> 16);
      if (s < 0) pass = 1'b0;
    end
    return pass;
  endfunction

  function automatic int rnd(input int lim);
    return int'($urandom_range(0, 2 * lim)) - lim;
  endfunction

  task automatic drive(input vec3_t pp, input vec3_t a0, input vec3_t a1, input vec3_t a2,
                       input vec3_t nn);
    p = pp; v0 = a0; v1 = a1; v2 = a2; normal = nn;
  endtask

  initial begin
    T0 = v3(0, 0, 0); T1 = v3(65536, 0, 0); T2 = v3(0, 65536, 0); NZ = v3(0, 0, 65536);
    tbl[0] = '{v3(16384, 16384, 0),      NZ,                  1'b1, 7, 7};
    tbl[1] = '{v3(65536, 65536, 0),      NZ,                  1'b0, 7, 5};
    tbl[2] = '{v3(32768, 32768, 0),      NZ,                  1'b1, 7, 7};
    tbl[3] = '{v3(-16384, 16384, 0),     NZ,                  1'b0, 7, 7};
    tbl[4] = '{v3(16384, -16384, 0),     NZ,                  1'b0, 7, 3};
    tbl[5] = '{v3(0, 0, 0),              NZ,                  1'b1, 7, 7};
    tbl[6] = '{v3(16384, 16384, 131072), v3(0, 0, -65536),    1'b0, 7, 3};
    tbl[7] = '{v3(65536, 65536, 0),      v3(0, 0, 0),         1'b1, 7, 7};

    reset = 1'b1; in_empty = 1'b0; out_rd_en = 1'b0;
    drive(T0, T0, T1, T2, NZ);
    repeat (2) @(negedge clock);
    chk("rst_out_empty", out_empty, 1);
    chk("rst_out_hit", out_hit, 0);
    chk("rst_out_p", out_p, 0);
    chk("rst_in_rd_en", in_rd_en, 0);
    in_empty = 1'b1;
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].p, T0, T1, T2, tbl[i].n);
      in_empty = 1'b0;
      #1;
      chk($sformatf("pop[%0d]", i), in_rd_en, 1);
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clock);
        if (k == 1) in_empty = 1'b1;
        if (!out_empty) begin
          lat = k;
          break;
        end
      end
      exp_lat = EE ? tbl[i].lat_ee : tbl[i].lat_def;
      chk($sformatf("lat[%0d]", i), lat, exp_lat);
      chk($sformatf("hit[%0d]", i), out_hit, tbl[i].hit);
      chk($sformatf("p[%0d]", i), out_p, tbl[i].p);
      out_rd_en = 1'b1;
      @(negedge clock);
      out_rd_en = 1'b0;
      chk($sformatf("drain[%0d]", i), out_empty, 1);
    end

    out_rd_en = 1'b1;
    @(negedge clock);
    out_rd_en = 1'b0;
    chk("rd_while_empty", out_empty, 1);

    // Back-to-back pair with the consumer idle: second result waits in DOT.
    PA = v3(16384, 16384, 0);
    PB = v3(32768, 16384, 0);
    drive(PA, T0, T1, T2, NZ);
    in_empty = 1'b0;
    #1;
    chk("b2b_pop1", in_rd_en, 1);
    @(negedge clock);
    drive(PB, T0, T1, T2, NZ);
    seen = 0;
    for (int k = 1; k <= 20; k++) begin
      if (in_rd_en) begin
        seen = k;
        break;
      end
      @(negedge clock);
    end
    chk("b2b_pop2_cycle", seen, 7);
    @(negedge clock);
    in_empty = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (out_empty || out_p !== PA || out_hit !== 1'b1) bad = 1'b1;
    end
    chk("stall_first_stable", bad, 0);
    out_rd_en = 1'b1;
    @(negedge clock);
    out_rd_en = 1'b0;
    chk("stall_replace_empty", out_empty, 0);
    chk("stall_replace_p", out_p, PB);
    chk("stall_replace_hit", out_hit, 1);
    out_rd_en = 1'b1;
    @(negedge clock);
    out_rd_en = 1'b0;
    chk("stall_drain", out_empty, 1);

    // Reset in cycle 3 of a transaction while an older result sits in the slot.
    drive(PA, T0, T1, T2, NZ);
    in_empty = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (k == 1) in_empty = 1'b1;
      if (!out_empty) begin
        lat = k;
        break;
      end
    end
    chk("rstseq_first_lat", lat, 7);
    drive(PB, T0, T1, T2, NZ);
    in_empty = 1'b0;
    #1;
    chk("rstseq_pop", in_rd_en, 1);
    @(negedge clock);
    in_empty = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    in_empty = 1'b0;
    #1;
    chk("rstmid_out_empty", out_empty, 1);
    chk("rstmid_out_hit", out_hit, 0);
    chk("rstmid_in_rd_en", in_rd_en, 0);
    repeat (2) @(negedge clock);
    chk("rstmid_hold_rd_en", in_rd_en, 0);
    in_empty = 1'b1;
    reset = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (!out_empty) bad = 1'b1;
    end
    chk("rst_no_stale", bad, 0);

    // Random triangles and points, random input gaps and consumer pops.
    npush = 0; ncons = 0; cyc = 0; need = 1'b1;
    while (ncons < NRAND && cyc < 6000) begin
      @(negedge clock);
      cyc++;
      out_rd_en = 1'b0;
      if (!out_empty && $urandom_range(0, 2) != 0) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rnd_underflow: got result with empty scoreboard p=%0h", out_p);
        end else begin
          r = q.pop_front();
          chk($sformatf("rnd_hit[%0d]", ncons), out_hit, r.hit);
          chk($sformatf("rnd_p[%0d]", ncons), out_p, r.p);
        end
        ncons++;
        out_rd_en = 1'b1;
      end
      if (npush < NRAND) begin
        if (need) begin
          ra = v3(rnd(131072), rnd(131072), rnd(131072));
          rb = v3(rnd(131072), rnd(131072), rnd(131072));
          rc = v3(rnd(131072), rnd(131072), rnd(131072));
          if ($urandom_range(0, 1) == 1) begin
            rn = vcross(vsub(rb, ra), vsub(rc, ra));
            rp = v3((ra[0] + rb[0] + rc[0]) / 3 + rnd(16384),
                    (ra[1] + rb[1] + rc[1]) / 3 + rnd(16384),
                    (ra[2] + rb[2] + rc[2]) / 3 + rnd(16384));
          end else begin
            rn = v3(rnd(131072), rnd(131072), rnd(131072));
            rp = v3(rnd(131072), rnd(131072), rnd(131072));
          end
          drive(rp, ra, rb, rc, rn);
          need = 1'b0;
        end
        in_empty = ($urandom_range(0, 2) == 0);
        #1;
        if (in_rd_en) begin
          chk($sformatf("rnd_pop_gated[%0d]", npush), in_empty, 0);
          q.push_back(res_t'{model_hit(rp, ra, rb, rc, rn), rp});
          npush++;
          need = 1'b1;
        end
      end else begin
        in_empty = 1'b1;
      end
    end
    out_rd_en = 1'b0;
    in_empty = 1'b1;
    chk("rnd_results", ncons, NRAND);
    chk("rnd_pops", npush, NRAND);
    chk("rnd_sb_left", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
